// File: rtl/ultrasonic_pkg.sv
// Shared types and defaults for the ultrasonic ranger.
// The FSM state encoding, 125 MHz timing defaults, and the all-ones timeout
// marker helper live here so every file agrees on them.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

  // Defaults for a 125 MHz clock: 10 us trigger, 30 ms timeout, 60 ms period.
  localparam int DEF_CNT_W          = 24;
  localparam int DEF_TRIG_CYCLES    = 1250;
  localparam int DEF_TIMEOUT_CYCLES = 3750000;
  localparam int DEF_PERIOD_CYCLES  = 7500000;

  // All-ones value of width w (up to 64 bits); callers cast to their width.
  function automatic logic [63:0] dist_all_ones(input int unsigned w);
    logic [63:0] ones;
    ones = '1;
    if (w >= 64) return ones;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the asynchronous echo input, plus single-cycle
// rise/fall strobes derived from the synchronised value and its previous value.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo_i,
  output logic echo_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain and one-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign echo_s_o = sync_q;
  assign rise_o   = sync_q & ~prev_q;
  assign fall_o   = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class ranger: periodic trigger pulses, echo width measured in clk
// cycles, all-ones plus timeout_o when the echo never rises or runs too long.
// Optional macro ULTRASONIC_AVG_EN: report the mean of the last 4 non-timeout
// widths (raw width until 4 samples have been collected).
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             echo_i,
  output logic             trig_o,
  output logic [CNT_W-1:0] dist_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST     = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIST_TIMEOUT = CNT_W'(dist_all_ones(CNT_W));

  logic echo_s, echo_rise, echo_fall;

  echo_sync u_echo_sync (
    .clk      (clk),
    .rst      (rst),
    .echo_i   (echo_i),
    .echo_s_o (echo_s),
    .rise_o   (echo_rise),
    .fall_o   (echo_fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;   // cycles since TRIG entry
  logic [CNT_W-1:0] phase_q, phase_d;     // cycles spent in TRIG / WAIT_RISE
  logic [CNT_W-1:0] width_q, width_d;     // echo width so far
  logic             trig_q, trig_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] dist_q, dist_d;
  logic             finish, finish_tmo;
  logic [CNT_W-1:0] result_width;

  // Next-state logic: sequencing, saturating counters and measurement finish.
  always_comb begin
    state_d    = state_q;
    period_d   = (period_q == CNT_MAX) ? period_q : period_q + ONE;
    phase_d    = phase_q;
    width_d    = width_q;
    finish     = 1'b0;
    finish_tmo = 1'b0;
    case (state_q)
      ST_IDLE: begin
        period_d = '0;
        phase_d  = '0;
        width_d  = '0;
        if (en_i) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        if (phase_q >= TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      ST_WAIT_RISE: begin
        // An echo already high on entry never produces a rise and times out.
        if (echo_rise) begin
          state_d = ST_MEASURE;
          width_d = ONE;
        end else if (phase_q >= TMO_LAST) begin
          finish     = 1'b1;
          finish_tmo = 1'b1;
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      ST_MEASURE: begin
        // Reaching the timeout width ends the measurement without the fall.
        if (echo_fall) begin
          finish = 1'b1;
        end else if (echo_s) begin
          if (width_q >= TMO_LAST) begin
            finish     = 1'b1;
            finish_tmo = 1'b1;
          end else begin
            width_d = width_q + ONE;
          end
        end
      end
      ST_HOLDOFF: begin
        if (period_q >= PER_LAST) begin
          period_d = '0;
          phase_d  = '0;
          state_d  = en_i ? ST_TRIG : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      state_d = ST_HOLDOFF;
      phase_d = '0;
    end

    trig_d  = (state_d == ST_TRIG);
    valid_d = finish;
    dist_d  = dist_q;
    tmo_d   = tmo_q;
    if (finish) begin
      tmo_d  = finish_tmo;
      dist_d = finish_tmo ? DIST_TIMEOUT : result_width;
    end
  end

  // State and output registers; reset drops trig_o without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      phase_q  <= '0;
      width_q  <= '0;
      trig_q   <= 1'b0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      dist_q   <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      width_q  <= width_d;
      trig_q   <= trig_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      dist_q   <= dist_d;
    end
  end

`ifdef ULTRASONIC_AVG_EN
  logic [CNT_W-1:0] hist_q [4];
  logic [2:0]       fill_q;
  logic [CNT_W+1:0] sum_q, sum_next;
  logic             commit;

  // Only completed, non-timeout measurements enter the running sum.
  assign commit       = finish & ~finish_tmo;
  assign sum_next     = sum_q + {2'b00, width_q} - {2'b00, hist_q[3]};
  assign result_width = (fill_q >= 3'd3) ? sum_next[CNT_W+1:2] : width_q;

  // Four-deep width history with running sum; the oldest entry drops out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      fill_q <= '0;
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (commit) begin
      sum_q <= sum_next;
      if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
      hist_q[0] <= width_q;
      for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
    end
  end
`else
  assign result_width = width_q;
`endif

  assign trig_o    = trig_q;
  assign dist_o    = dist_q;
  assign valid_o   = valid_q;
  assign timeout_o = tmo_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with short timing parameters.
// A period-level model predicts every output each cycle from the recorded
// synchronised echo; directed scenarios add hand-computed literal checks.
module tb_ultrasonic_ranger;

  localparam int TRIG = 10;
  localparam int TMO  = 1000;
  localparam int PER  = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0;
  logic        echo_i = 1'b0;
  logic        trig_o, valid_o, timeout_o, busy_o;
  logic [23:0] dist_o;

  ultrasonic_ranger #(
    .CNT_W(24), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .PERIOD_CYCLES(PER)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .echo_i(echo_i), .trig_o(trig_o),
    .dist_o(dist_o), .valid_o(valid_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model ----------------
  bit echo_at [0:65535];
  bit rst_at  [0:65535];
  bit es      [0:65535];   // synchronised echo as seen in each cycle

  bit          m_active, m_resolved;
  int          m_p, m_vc;
  logic [23:0] m_rdist;
  bit          m_rtmo;
  logic [23:0] exp_dist = '0;
  bit          exp_tmo, exp_valid, exp_trig, exp_busy;
  logic [23:0] avg_q [$];

  // Work out when this period's result appears, using echo seen up to k-1.
  task automatic resolve(input int k);
    int r;
    r = -1;
    for (int c = m_p + TRIG; c <= m_p + TRIG + TMO - 1 && c <= k - 1; c++) begin
      if (es[c] && !es[c-1]) begin
        r = c;
        break;
      end
    end
    if (r < 0) begin
      if (k - 1 >= m_p + TRIG + TMO - 1) begin
        m_resolved = 1; m_vc = m_p + TRIG + TMO; m_rtmo = 1;
      end
      return;
    end
    for (int j = 1; j < TMO; j++) begin
      if (r + j > k - 1) return;
      if (!es[r+j]) begin
        m_resolved = 1; m_vc = r + j + 1; m_rdist = 24'(j); m_rtmo = 0;
        return;
      end
    end
    m_resolved = 1; m_vc = r + TMO; m_rtmo = 1;
  endtask

  task automatic model_step(input int k, input bit rst_now, input bit en_now);
    int s;
    exp_valid = 0;
    if (rst_now) begin
      m_active = 0; exp_dist = '0; exp_tmo = 0; avg_q.delete();
    end else if (!m_active) begin
      if (en_now) begin m_active = 1; m_p = k; m_resolved = 0; end
    end else begin
      if (k - m_p == PER) begin
        if (en_now) begin m_p = k; m_resolved = 0; end
        else m_active = 0;
      end
      if (m_active && !m_resolved) resolve(k);
      if (m_active && m_resolved && m_vc == k) begin
        exp_valid = 1;
        if (m_rtmo) begin
          exp_dist = 24'hFFFFFF; exp_tmo = 1;
        end else begin
          exp_tmo = 0;
`ifdef ULTRASONIC_AVG_EN
          avg_q.push_back(m_rdist);
          if (avg_q.size() > 4) avg_q.delete(0);
          s = 0;
          foreach (avg_q[i]) s += int'(avg_q[i]);
          exp_dist = (avg_q.size() == 4) ? 24'(s / 4) : m_rdist;
`else
          s = 0;
          exp_dist = m_rdist + 24'(s);
`endif
        end
      end
    end
    exp_trig = m_active && (k - m_p) < TRIG;
    exp_busy = m_active;
  endtask

  // ---------------- per-cycle compare and observation ----------------
  int valid_cnt = 0, last_vc = 0, trig_rises = 0, trig_rise_cyc = 0;
  int trig_fall_cyc = 0, trig_hi = 0, last_trig_hi = 0;
  logic [23:0] last_dist = '0;
  logic last_tmo = 1'b0, trig_prev = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    echo_at[cyc] = echo_i;
    rst_at[cyc]  = rst;
    es[cyc] = (rst || rst_at[cyc-1]) ? 1'b0 : echo_at[cyc-1];
    model_step(cyc, rst, en_i);
    #1;
    check("trig_o", {31'd0, trig_o}, {31'd0, exp_trig});
    check("busy_o", {31'd0, busy_o}, {31'd0, exp_busy});
    check("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
    check("timeout_o", {31'd0, timeout_o}, {31'd0, exp_tmo});
    check("dist_o", {8'd0, dist_o}, {8'd0, exp_dist});
    if (trig_o && !trig_prev) begin trig_rises++; trig_rise_cyc = cyc; trig_hi = 0; end
    if (trig_o) trig_hi++;
    if (!trig_o && trig_prev) begin trig_fall_cyc = cyc; last_trig_hi = trig_hi; end
    trig_prev = trig_o;
    if (valid_o) begin
      valid_cnt++; last_vc = cyc; last_dist = dist_o; last_tmo = timeout_o;
      $display("[TB] txn %0d: cycle %0d dist=%0d timeout=%0b", valid_cnt, cyc, dist_o, timeout_o);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_trig_fall(input string name, output int fall_cyc);
    int n;
    n = 0;
    while (!trig_o && n < 5000) begin @(negedge clk); n++; end
    while (trig_o && n < 5000) begin @(negedge clk); n++; end
    check(name, {31'd0, (n >= 5000)}, 32'd0);
    fall_cyc = trig_fall_cyc;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n0, n;
    n0 = valid_cnt; n = 0;
    while (valid_cnt == n0 && n < budget) begin @(negedge clk); n++; end
    check(name, {31'd0, (valid_cnt == n0)}, 32'd0);
  endtask

  task automatic echo_pulse(input int delay, input int width);
    repeat (delay) @(negedge clk);
    echo_i = 1'b1;
    repeat (width) @(negedge clk);
    echo_i = 1'b0;
  endtask

  initial begin
    #600000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- directed scenarios ----------------
  int f, f2, rise_a, vcnt0, tr0, n;
  int widths [5];
  int want [5];

  initial begin
    widths = '{100, 200, 300, 400, 500};
`ifdef ULTRASONIC_AVG_EN
    want = '{100, 200, 300, 250, 350};
`else
    want = '{100, 200, 300, 400, 500};
`endif
    repeat (3) @(negedge clk);
    check("rst_trig", {31'd0, trig_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    check("rst_dist", {8'd0, dist_o}, 32'd0);
    rst = 1'b0;
    en_i = 1'b1;

    // 250-cycle echo starting 40 cycles after trig falls
    wait_trig_fall("s1_trig_wait", f);
    check("s1_trig_width", last_trig_hi, 10);
    echo_pulse(40, 250);
    wait_valid(20, "s1_valid_wait");
    check("s1_dist", {8'd0, last_dist}, 250);
    check("s1_timeout", {31'd0, last_tmo}, 0);
    check("s1_latency", last_vc - f, 293);

    // echo held low: timeout 1000 cycles after trig falls
    wait_trig_fall("s2_trig_wait", f2);
    rise_a = trig_rise_cyc;
    wait_valid(1100, "s2_valid_wait");
    check("s2_latency", last_vc - f2, 1000);
    check("s2_dist", {8'd0, last_dist}, 32'h00FFFFFF);
    check("s2_timeout", {31'd0, last_tmo}, 1);

    // echo high 1500 cycles: timeout when width reaches 1000, single valid
    wait_trig_fall("s3_trig_wait", f);
    check("s2_period", trig_rise_cyc - rise_a, 3000);
    vcnt0 = valid_cnt;
    echo_pulse(40, 1500);
    check("s3_latency", last_vc - f, 1042);
    check("s3_dist", {8'd0, last_dist}, 32'h00FFFFFF);
    check("s3_timeout", {31'd0, last_tmo}, 1);

    // en_i dropped mid-measurement, width 100
    wait_trig_fall("s4_trig_wait", f);
    check("s3_single_valid", valid_cnt - vcnt0, 1);
    repeat (40) @(negedge clk);
    echo_i = 1'b1;
    repeat (50) @(negedge clk);
    en_i = 1'b0;
    repeat (50) @(negedge clk);
    echo_i = 1'b0;
    wait_valid(20, "s4_valid_wait");
    check("s4_dist", {8'd0, last_dist}, 100);
    check("s4_timeout", {31'd0, last_tmo}, 0);
    n = 0;
    while (busy_o && n < 4000) begin @(negedge clk); n++; end
    check("s4_idle_wait", {31'd0, (n >= 4000)}, 32'd0);
    tr0 = trig_rises;
    repeat (3500) @(negedge clk);
    check("s4_no_trig", trig_rises - tr0, 0);
    check("s4_busy", {31'd0, busy_o}, 0);

    // reset pulsed mid-TRIG
    en_i = 1'b1;
    n = 0;
    while (!trig_o && n < 20) begin @(negedge clk); n++; end
    check("s5_trig_wait", {31'd0, (n >= 20)}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s5_trig_async", {31'd0, trig_o}, 0);
    check("s5_busy", {31'd0, busy_o}, 0);
    check("s5_valid", {31'd0, valid_o}, 0);
    check("s5_timeout", {31'd0, timeout_o}, 0);
    check("s5_dist", {8'd0, dist_o}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // width sequence 100..500 after reset (averaged when the option is built)
    for (int i = 0; i < 5; i++) begin
      wait_trig_fall("s6_trig_wait", f);
      echo_pulse(40, widths[i]);
      wait_valid(20, "s6_valid_wait");
      check("s6_dist", {8'd0, last_dist}, want[i]);
      check("s6_timeout", {31'd0, last_tmo}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
